// File: rtl/board_arb_pkg.sv
// Shared types and constants for the board access arbiter.
package board_arb_pkg;

  localparam int unsigned ROW_BITS_DEF = 3;
  localparam int unsigned COL_BITS_DEF = 3;

  // Requester identity carried with each access
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_GAME = 2'd1,
    REQ_CHK  = 2'd2,
    REQ_DISP = 2'd3
  } req_id_e;

  // Cell contents stored in the board
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PLAYER1 = 2'd1,
    PLAYER2 = 2'd2
  } player_e;

  // One stage of the read-return pipe
  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rsp_tag_t;

endpackage

// File: rtl/board_rsp_pipe.sv
// Read-return pipe: delays the granted requester id by the board read
// latency, then emits a one-cycle rvalid to that requester with the
// registered board data.
module board_rsp_pipe
  import board_arb_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_id,
  input  logic [1:0] mem_data,
  output logic       g_rvalid,
  output logic       v_rvalid,
  output logic       d_rvalid,
  output logic [1:0] rdata
);

  rsp_tag_t pipe_q [RD_LATENCY];
  rsp_tag_t tail;

  assign tail = pipe_q[RD_LATENCY-1];

  // Shift the requester tag along while the board produces the data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0].valid <= in_valid;
      pipe_q[0].id    <= req_id_e'(in_id);
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Decode the tag at the pipe tail into per-requester valids; capture data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_rvalid <= 1'b0;
      v_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      rdata    <= 2'd0;
    end else begin
      g_rvalid <= tail.valid && (tail.id == REQ_GAME);
      v_rvalid <= tail.valid && (tail.id == REQ_CHK);
      d_rvalid <= tail.valid && (tail.id == REQ_DISP);
      if (tail.valid) begin
        rdata <= mem_data;
      end
    end
  end

endmodule

// File: rtl/board_access_arbiter.sv
// Fixed-priority arbiter sharing the board port between the game FSM,
// victory checker and display scanner, with a starvation guard that lifts
// the display to top priority after STARVE_LIMIT consecutive lost cycles.
module board_access_arbiter
  import board_arb_pkg::*;
#(
  parameter int unsigned ROW_BITS     = ROW_BITS_DEF,
  parameter int unsigned COL_BITS     = COL_BITS_DEF,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned RD_LATENCY   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                g_req,
  input  logic                g_wr,
  input  logic [ROW_BITS-1:0] g_row,
  input  logic [COL_BITS-1:0] g_col,
  input  logic [1:0]          g_wdata,
  output logic                g_gnt,
  output logic                g_rvalid,
  input  logic                v_req,
  input  logic [ROW_BITS-1:0] v_row,
  input  logic [COL_BITS-1:0] v_col,
  output logic                v_gnt,
  output logic                v_rvalid,
  input  logic                d_req,
  input  logic [ROW_BITS-1:0] d_row,
  input  logic [COL_BITS-1:0] d_col,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [1:0]          rdata,
  output logic [ROW_BITS-1:0] mem_row,
  output logic [COL_BITS-1:0] mem_col,
  output logic                mem_write,
  output logic [1:0]          mem_wdata,
  input  logic [1:0]          mem_data
);

  req_id_e             win_d;
  req_id_e             rd_id_q;
  logic [2:0]          starve_q, starve_d;
  logic [ROW_BITS-1:0] row_mux;
  logic [COL_BITS-1:0] col_mux;
  logic                starved;

  assign starved = d_req && (32'(starve_q) >= STARVE_LIMIT);

  // Pick the winner for this cycle and the next starvation count
  always_comb begin
    win_d    = REQ_NONE;
    starve_d = starve_q;
    row_mux  = mem_row;
    col_mux  = mem_col;
    if (starved) begin
      win_d = REQ_DISP;
    end else if (g_req) begin
      win_d = REQ_GAME;
    end else if (v_req) begin
      win_d = REQ_CHK;
    end else if (d_req) begin
      win_d = REQ_DISP;
    end
    unique case (win_d)
      REQ_GAME: begin row_mux = g_row; col_mux = g_col; end
      REQ_CHK:  begin row_mux = v_row; col_mux = v_col; end
      REQ_DISP: begin row_mux = d_row; col_mux = d_col; end
      default:  ;
    endcase
    if (!d_req || win_d == REQ_DISP) begin
      starve_d = 3'd0;
    end else if (starve_q != 3'd7) begin
      starve_d = starve_q + 3'd1;
    end
  end

  // Register grants and the board address/control; hold address when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_gnt     <= 1'b0;
      v_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      mem_write <= 1'b0;
      mem_row   <= '0;
      mem_col   <= '0;
      mem_wdata <= 2'd0;
      starve_q  <= 3'd0;
      rd_id_q   <= REQ_NONE;
    end else begin
      g_gnt     <= (win_d == REQ_GAME);
      v_gnt     <= (win_d == REQ_CHK);
      d_gnt     <= (win_d == REQ_DISP);
      mem_write <= (win_d == REQ_GAME) && g_wr;
      mem_row   <= row_mux;
      mem_col   <= col_mux;
      starve_q  <= starve_d;
      if (win_d == REQ_GAME) begin
        mem_wdata <= g_wdata;
      end
      // Only reads travel down the return pipe
      rd_id_q   <= (win_d == REQ_GAME && g_wr) ? REQ_NONE : win_d;
    end
  end

  board_rsp_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rsp_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_id_q != REQ_NONE),
    .in_id    (rd_id_q),
    .mem_data (mem_data),
    .g_rvalid (g_rvalid),
    .v_rvalid (v_rvalid),
    .d_rvalid (d_rvalid),
    .rdata    (rdata)
  );

endmodule

// File: tb/tb_board_access_arbiter.sv
// Bench for board_access_arbiter: two instances (read latency 1 and 2)
// share one stimulus stream and are scored against a cycle-level model.
module tb_board_access_arbiter;
  import board_arb_pkg::*;

  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       g_req = 0, g_wr = 0, v_req = 0, d_req = 0;
  logic [2:0] g_row = 0, g_col = 0, v_row = 0, v_col = 0, d_row = 0, d_col = 0;
  logic [1:0] g_wdata = 0;

  logic       g_gnt_a, g_rvalid_a, v_gnt_a, v_rvalid_a, d_gnt_a, d_rvalid_a, mem_write_a;
  logic       g_gnt_b, g_rvalid_b, v_gnt_b, v_rvalid_b, d_gnt_b, d_rvalid_b, mem_write_b;
  logic [1:0] rdata_a, mem_wdata_a, mem_data_a, rdata_b, mem_wdata_b, mem_data_b;
  logic [2:0] mem_row_a, mem_col_a, mem_row_b, mem_col_b;

  board_access_arbiter #(.ROW_BITS(3), .COL_BITS(3), .STARVE_LIMIT(SL), .RD_LATENCY(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .g_req(g_req), .g_wr(g_wr), .g_row(g_row), .g_col(g_col), .g_wdata(g_wdata),
    .g_gnt(g_gnt_a), .g_rvalid(g_rvalid_a),
    .v_req(v_req), .v_row(v_row), .v_col(v_col), .v_gnt(v_gnt_a), .v_rvalid(v_rvalid_a),
    .d_req(d_req), .d_row(d_row), .d_col(d_col), .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a),
    .rdata(rdata_a), .mem_row(mem_row_a), .mem_col(mem_col_a), .mem_write(mem_write_a),
    .mem_wdata(mem_wdata_a), .mem_data(mem_data_a)
  );

  board_access_arbiter #(.ROW_BITS(3), .COL_BITS(3), .STARVE_LIMIT(SL), .RD_LATENCY(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .g_req(g_req), .g_wr(g_wr), .g_row(g_row), .g_col(g_col), .g_wdata(g_wdata),
    .g_gnt(g_gnt_b), .g_rvalid(g_rvalid_b),
    .v_req(v_req), .v_row(v_row), .v_col(v_col), .v_gnt(v_gnt_b), .v_rvalid(v_rvalid_b),
    .d_req(d_req), .d_row(d_row), .d_col(d_col), .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b),
    .rdata(rdata_b), .mem_row(mem_row_b), .mem_col(mem_col_b), .mem_write(mem_write_b),
    .mem_wdata(mem_wdata_b), .mem_data(mem_data_b)
  );

  // Board storage behind each instance: write-first, 1 or 2 cycle reads
  logic [1:0] board_a [64];
  logic [1:0] board_b [64];
  logic [1:0] ra1, rb1, rb2;

  always @(posedge clk) begin
    if (mem_write_a) board_a[{mem_row_a, mem_col_a}] <= mem_wdata_a;
    ra1 <= mem_write_a ? mem_wdata_a : board_a[{mem_row_a, mem_col_a}];
    if (mem_write_b) board_b[{mem_row_b, mem_col_b}] <= mem_wdata_b;
    rb1 <= mem_write_b ? mem_wdata_b : board_b[{mem_row_b, mem_col_b}];
    rb2 <= rb1;
  end
  assign mem_data_a = ra1;
  assign mem_data_b = rb2;

  // Reference model state
  int         n_chk = 0, n_pass = 0;
  int         k = 0;
  int         starve = 0;
  int         last_w = 0;
  logic [1:0] ref_board [64];
  int         sched_id [2048];
  logic [1:0] sched_d [2048];
  logic [2:0] exp_gnt = 0;
  logic       exp_we = 0;
  logic [2:0] e_row = 0, e_col = 0;
  logic [1:0] e_wdata = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s at step %0d: got %0h expected %0h", tag, k, got, exp);
    else n_pass++;
  endtask

  function automatic logic [2:0] onehot(input int id);
    case (id)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check_out();
    logic [2:0] rv_a, rv_b;
    rv_a = (k >= 2) ? onehot(sched_id[k-2]) : 3'b000;
    rv_b = (k >= 3) ? onehot(sched_id[k-3]) : 3'b000;
    chk("gnt_a", {g_gnt_a, v_gnt_a, d_gnt_a}, exp_gnt);
    chk("gnt_b", {g_gnt_b, v_gnt_b, d_gnt_b}, exp_gnt);
    chk("we_a", mem_write_a, exp_we);
    chk("we_b", mem_write_b, exp_we);
    chk("addr_a", {mem_row_a, mem_col_a}, {e_row, e_col});
    chk("addr_b", {mem_row_b, mem_col_b}, {e_row, e_col});
    chk("wdata_a", mem_wdata_a, e_wdata);
    chk("wdata_b", mem_wdata_b, e_wdata);
    chk("rvalid_a", {g_rvalid_a, v_rvalid_a, d_rvalid_a}, rv_a);
    chk("rvalid_b", {g_rvalid_b, v_rvalid_b, d_rvalid_b}, rv_b);
    if (rv_a != 0) chk("rdata_a", rdata_a, sched_d[k-2]);
    if (rv_b != 0) chk("rdata_b", rdata_b, sched_d[k-3]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, {g_gnt_a, v_gnt_a, d_gnt_a, g_rvalid_a, v_rvalid_a, d_rvalid_a,
                      mem_write_a, mem_row_a, mem_col_a, mem_wdata_a, rdata_a}, 0);
    chk({tag, "_b"}, {g_gnt_b, v_gnt_b, d_gnt_b, g_rvalid_b, v_rvalid_b, d_rvalid_b,
                      mem_write_b, mem_row_b, mem_col_b, mem_wdata_b, rdata_b}, 0);
  endtask

  // Apply the priority rules to the current requests, advance one clock, score
  task automatic step();
    int         w;
    logic [5:0] a;
    w = 0;
    if (d_req && starve >= SL) w = 3;
    else if (g_req)            w = 1;
    else if (v_req)            w = 2;
    else if (d_req)            w = 3;
    starve = (!d_req || w == 3) ? 0 : ((starve < 7) ? starve + 1 : 7);
    exp_gnt = onehot(w);
    exp_we = 1'b0;
    sched_id[k] = 0;
    if (w == 1) begin e_row = g_row; e_col = g_col; e_wdata = g_wdata; end
    if (w == 2) begin e_row = v_row; e_col = v_col; end
    if (w == 3) begin e_row = d_row; e_col = d_col; end
    a = {e_row, e_col};
    if (w == 1 && g_wr) begin
      exp_we = 1'b1;
      ref_board[a] = g_wdata;
    end else if (w != 0) begin
      sched_id[k] = w;
      sched_d[k] = ref_board[a];
    end
    last_w = w;
    @(posedge clk);
    @(negedge clk);
    check_out();
    k++;
  endtask

  task automatic idle(input int n);
    g_req = 0; v_req = 0; d_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin sched_id[i] = 0; sched_d[i] = 0; end
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Fill the board with back-to-back game writes
    for (int i = 0; i < 64; i++) begin
      g_req = 1; g_wr = 1; g_row = 3'(i >> 3); g_col = 3'(i); g_wdata = 2'($urandom_range(0, 2));
      step();
    end

    // Write then immediately read the same cell
    g_row = 3'd7; g_col = 3'd3; g_wdata = PLAYER1;
    step();
    g_req = 0; v_req = 1; v_row = 3'd7; v_col = 3'd3;
    step();
    idle(4);

    // Reset while a checker read is in flight
    v_req = 1; v_row = 3'd2; v_col = 3'd5;
    step();
    v_req = 0;
    #2 rst = 1'b1;
    #1 chk_zero("mid_rst");
    @(posedge clk);
    @(negedge clk);
    chk_zero("mid_rst_hold");
    rst = 1'b0;
    for (int i = 0; i <= k; i++) sched_id[i] = 0;
    starve = 0; e_row = 0; e_col = 0; e_wdata = 0;
    k++;
    idle(5);

    // All three requesting: display promoted once its counter reaches the limit
    g_req = 1; g_wr = 0; g_row = 3'd1; g_col = 3'd1;
    v_req = 1; v_row = 3'd2; v_col = 3'd2;
    d_req = 1; d_row = 3'd3; d_col = 3'd3;
    for (int i = 0; i < 6; i++) step();
    idle(4);

    // Streaming checker reads across row 0
    v_req = 1; v_row = 3'd0;
    for (int i = 0; i < 8; i++) begin v_col = 3'(i); step(); end
    idle(10);

    // Random traffic honouring hold-until-granted
    for (int n = 0; n < 400; n++) begin
      if (!g_req || last_w == 1) begin
        g_req = ($urandom_range(0, 9) < 6); g_wr = 1'($urandom_range(0, 1));
        g_row = 3'($urandom); g_col = 3'($urandom); g_wdata = 2'($urandom_range(0, 2));
      end
      if (!v_req || last_w == 2) begin
        v_req = 1'($urandom_range(0, 1)); v_row = 3'($urandom); v_col = 3'($urandom);
      end
      if (!d_req || last_w == 3) begin
        d_req = 1'($urandom_range(0, 1)); d_row = 3'($urandom); d_col = 3'($urandom);
      end
      step();
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/board_access_arbiter.md
Name: board_access_arbiter

Overview:
Shares the single board_rw access port among three requesters:
- Game FSM: drop writes and reads.
- Victory checker: reads.
- Display scanner: reads.

It replaces the hard state-based address mux with a pipelined request/grant scheme and fixed priority, plus a starvation guard for the display. It sits between connect_four's control logic and board_rw.

Parameters:
ROW_BITS, 3, board row index width
COL_BITS, 3, board column index width
STARVE_LIMIT, 4, consecutive lost cycles after which the display requester is promoted to top priority (range 1..7)
RD_LATENCY, 1, cycles from mem address/control to valid mem_data (legal values 1 or 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
g_req  in  1  game request
g_wr  in  1  game request is a write
g_row  in  ROW_BITS  game row
g_col  in  COL_BITS  game column
g_wdata  in  2  game write data (player id)
g_gnt  out  1  game grant pulse
g_rvalid  out  1  game read data valid pulse
v_req  in  1  victory-checker read request
v_row  in  ROW_BITS  checker row
v_col  in  COL_BITS  checker column
v_gnt  out  1  checker grant pulse
v_rvalid  out  1  checker read data valid pulse
d_req  in  1  display read request
d_row  in  ROW_BITS  display row
d_col  in  COL_BITS  display column
d_gnt  out  1  display grant pulse
d_rvalid  out  1  display read data valid pulse
rdata  out  2  shared read return data; qualify with *_rvalid
mem_row  out  ROW_BITS  board address row (registered)
mem_col  out  COL_BITS  board address column (registered)
mem_write  out  1  board write strobe (registered)
mem_wdata  out  2  board write data (registered)
mem_data  in  2  board read data

Behaviour:
- Reset (async, rst=1):
  - All gnt, rvalid and mem_write = 0.
  - mem_row, mem_col, mem_wdata, rdata = 0.
  - Starvation counter = 0; return pipe cleared.
  - A reset mid-access drops any pending return; no rvalid is emitted after reset releases.
- Arbitration (combinational on cycle t, over requests sampled in t):
  - Default order: game > checker > display.
  - If starve_cnt >= STARVE_LIMIT and d_req=1, display wins outright.
  - At most one grant per cycle.
- Grant (cycle t+1, registered):
  - Winner's gnt=1 for exactly one cycle.
  - mem_row/mem_col take the winner's address; mem_write=g_wr if game won, else 0.
  - mem_wdata=g_wdata when game wins.
- Requester rule:
  - Hold req and address stable until gnt is seen.
  - Req may stay high for back-to-back accesses; the arbiter re-arbitrates every cycle.
  - Throughput is one access per cycle.
  - A req still high in the grant cycle is a new request.
- No grant:
  - mem_write=0; mem_row/mem_col/mem_wdata hold their last values.
  - No gnt asserted.
- Read return:
  - For a granted read, the matching *_rvalid=1 for one cycle, RD_LATENCY+1 cycles after gnt.
  - rdata = mem_data sampled at that point (registered).
  - Requester id travels with the access through a RD_LATENCY-deep shift pipe.
- Writes:
  - Writes produce no rvalid.
  - A read granted the cycle after a write to the same cell returns the new value (board_rw write-first).
- Starvation counter:
  - Increments (saturating at 7) on each cycle d_req=1 and display not granted.
  - Cleared when display is granted or d_req=0.
- Simultaneous events: all three requesting with counter below limit → game granted; checker and display wait. The counter increments.

Decomposition:
- Package board_arb_pkg holds:
  - requester ids: REQ_NONE=2'd0, REQ_GAME=2'd1, REQ_CHK=2'd2, REQ_DISP=2'd3
  - ROW_BITS/COL_BITS defaults
  - player codes EMPTY/PLAYER1/PLAYER2
- One sub-module, board_rsp_pipe: parameterised RD_LATENCY shift register carrying {valid, requester id}. It decodes the three rvalid outputs and registers rdata.
- Arbitration and starvation logic stay in the top module.

Test Plan:
- Reset with rst pulsed during an in-flight checker read (gnt seen, rvalid pending) → no v_rvalid ever; all outputs 0; starve_cnt 0.
- g_req=1, g_wr=1, row 7, col 3, wdata 2'b01 alone → next cycle g_gnt=1, mem_write=1, mem_row=7, mem_col=3, mem_wdata=01; no g_rvalid. Then v_req at (7,3) → v_rvalid with rdata=01 two cycles after v_gnt (RD_LATENCY=1).
- g_req, v_req, d_req all held high for 6 cycles (STARVE_LIMIT=4) → g_gnt cycles 1–4; d_gnt in cycle 5 (counter reached 4); counter cleared; g_gnt again in cycle 6; v_gnt never.
- v_req held with incrementing addresses (0,0)…(0,7) over 8 cycles → 8 consecutive v_gnt, 8 v_rvalid pulses in order, rdata matching the preloaded board.
- RD_LATENCY=2 build, single display read → d_rvalid exactly 3 cycles after d_gnt; no other rvalid asserted.
- No requests for 10 cycles after a grant → mem_write=0, mem_row/mem_col unchanged, no gnt or rvalid.
